// File: rtl/result_trace_fifo.sv
// Result-bus trace FIFO: captures in_data while cap_en is high and drains it over valid/ready, counting drops when full.
// Latency 1 cycle from capture to out_valid; optional STOP_ON_FULL halt; define TRACE_DEDUP_EN to suppress repeated values.
module result_trace_fifo #(
  parameter int WIDTH        = 32,
  parameter int DEPTH        = 16,
  parameter int CNT_W        = 16,
  parameter int STOP_ON_FULL = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     cap_en,
  input  logic [WIDTH-1:0]         in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty,
  output logic                     done,
  output logic [CNT_W-1:0]         overflow_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {IDLE, CAPTURE, HALTED} state_t;

  state_t           state;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [CW-1:0]    cnt;
  logic [CW-1:0]    cnt_nxt;
  logic             dup;
  logic             push_req;
  logic             push;
  logic             pop;
  logic             drop;

`ifdef TRACE_DEDUP_EN
  logic [WIDTH-1:0] last_val;
  logic             last_vld;

  assign dup = last_vld && (in_data == last_val);

  // last_val tracks the last value actually stored, independent of pops
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      last_val <= '0;
      last_vld <= 1'b0;
    end else if (push) begin
      last_val <= in_data;
      last_vld <= 1'b1;
    end
  end
`else
  assign dup = 1'b0;
`endif

  assign empty     = (cnt == '0);
  assign full      = (cnt == CW'(DEPTH));
  assign count     = cnt;
  assign out_valid = !empty;
  assign out_data  = empty ? '0 : mem[rd_ptr];
  assign done      = (state == HALTED);

  assign push_req = cap_en && (state != HALTED) && !dup;
  assign pop      = out_valid && out_ready;
  assign push     = push_req && (!full || pop);
  assign drop     = push_req && full && !pop && (STOP_ON_FULL == 0);

  always_comb begin
    cnt_nxt = cnt;
    if (push && !pop)
      cnt_nxt = cnt + CW'(1);
    else if (pop && !push)
      cnt_nxt = cnt - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= in_data;
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      cnt          <= '0;
      overflow_cnt <= '0;
      state        <= IDLE;
    end else begin
      cnt <= cnt_nxt;
      if (push)
        wr_ptr <= wr_ptr + AW'(1);
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);
      if (drop && (overflow_cnt != '1))
        overflow_cnt <= overflow_cnt + CNT_W'(1);

      if ((STOP_ON_FULL != 0) && push && (cnt_nxt == CW'(DEPTH))) begin
        state <= HALTED;
      end else begin
        case (state)
          IDLE:    if (cap_en) state <= CAPTURE;
          CAPTURE: if (!cap_en) state <= IDLE;
          default: state <= state;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_result_trace_fifo.sv
// Scoreboard bench: two DEPTH=4 instances, one dropping when full and one halting when full.
module tb_result_trace_fifo;

  logic        clk = 1'b0;
  logic        rst, clr;
  logic        cap_en_a, out_ready_a, cap_en_b, out_ready_b;
  logic [31:0] in_data_a, in_data_b;
  logic        out_valid_a, full_a, empty_a, done_a;
  logic        out_valid_b, full_b, empty_b, done_b;
  logic [31:0] out_data_a, out_data_b;
  logic [2:0]  count_a, count_b;
  logic [15:0] ovf_a, ovf_b;

  int checks = 0;
  int errors = 0;
  logic [31:0] qa[$];
  logic [31:0] qb[$];

  always #5 clk = ~clk;

  result_trace_fifo #(.WIDTH(32), .DEPTH(4), .CNT_W(16), .STOP_ON_FULL(0)) dut_a (
    .clk(clk), .rst(rst), .clr(clr), .cap_en(cap_en_a), .in_data(in_data_a),
    .out_valid(out_valid_a), .out_ready(out_ready_a), .out_data(out_data_a),
    .count(count_a), .full(full_a), .empty(empty_a), .done(done_a), .overflow_cnt(ovf_a));

  result_trace_fifo #(.WIDTH(32), .DEPTH(4), .CNT_W(16), .STOP_ON_FULL(1)) dut_b (
    .clk(clk), .rst(rst), .clr(clr), .cap_en(cap_en_b), .in_data(in_data_b),
    .out_valid(out_valid_b), .out_ready(out_ready_b), .out_data(out_data_b),
    .count(count_b), .full(full_b), .empty(empty_b), .done(done_b), .overflow_cnt(ovf_b));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitors: every accepted head is compared against the oldest expected value.
  always @(negedge clk) begin
    if (!rst && out_valid_a && out_ready_a) begin
      checks++;
      if (qa.size() == 0) begin
        errors++;
        $display("FAIL pop_a: got %0d expected no data", out_data_a);
      end else begin
        logic [31:0] e;
        e = qa.pop_front();
        if (out_data_a !== e) begin
          errors++;
          $display("FAIL pop_a: got %0d expected %0d", out_data_a, e);
        end
      end
    end
    if (!rst && out_valid_b && out_ready_b) begin
      checks++;
      if (qb.size() == 0) begin
        errors++;
        $display("FAIL pop_b: got %0d expected no data", out_data_b);
      end else begin
        logic [31:0] e;
        e = qb.pop_front();
        if (out_data_b !== e) begin
          errors++;
          $display("FAIL pop_b: got %0d expected %0d", out_data_b, e);
        end
      end
    end
  end

  initial begin
    rst = 1'b1; clr = 1'b0;
    cap_en_a = 1'b0; out_ready_a = 1'b0; in_data_a = '0;
    cap_en_b = 1'b0; out_ready_b = 1'b0; in_data_b = '0;
    step();
    rst = 1'b0;
    check("rst_count", 32'(count_a), 0);
    check("rst_empty", 32'(empty_a), 1);
    check("rst_valid", 32'(out_valid_a), 0);
    check("rst_data", out_data_a, 0);
    check("rst_done", 32'(done_b), 0);
    check("rst_ovf", 32'(ovf_a), 0);

    // capture three samples, no reader
    cap_en_a = 1'b1;
    for (int v = 1; v <= 3; v++) begin
      in_data_a = 32'(v); qa.push_back(32'(v)); step();
    end
    cap_en_a = 1'b0;
    check("t1_count", 32'(count_a), 3);
    check("t1_valid", 32'(out_valid_a), 1);
    check("t1_head", out_data_a, 1);
    check("t1_ovf", 32'(ovf_a), 0);
    out_ready_a = 1'b1; step(3); out_ready_a = 1'b0;
    check("t1_empty", 32'(empty_a), 1);

    // overflow with drop counting
    cap_en_a = 1'b1;
    for (int v = 10; v <= 15; v++) begin
      in_data_a = 32'(v);
      if (v <= 13) qa.push_back(32'(v));
      step();
    end
    cap_en_a = 1'b0;
    check("t2_full", 32'(full_a), 1);
    check("t2_count", 32'(count_a), 4);
    check("t2_ovf", 32'(ovf_a), 2);
    out_ready_a = 1'b1; step(4); out_ready_a = 1'b0;
    check("t2_empty", 32'(empty_a), 1);
    check("t2_data0", out_data_a, 0);

    // full + push + pop on the same edge
    clr = 1'b1; step(); clr = 1'b0;
    check("clr_ovf", 32'(ovf_a), 0);
    cap_en_a = 1'b1;
    for (int v = 1; v <= 4; v++) begin
      in_data_a = 32'(v); qa.push_back(32'(v)); step();
    end
    in_data_a = 5; out_ready_a = 1'b1; qa.push_back(5); step();
    cap_en_a = 1'b0; out_ready_a = 1'b0;
    check("t3_count", 32'(count_a), 4);
    check("t3_ovf", 32'(ovf_a), 0);
    check("t3_head", out_data_a, 2);
    out_ready_a = 1'b1; step(4); out_ready_a = 1'b0;

    // stop-on-full instance
    cap_en_b = 1'b1;
    for (int v = 1; v <= 5; v++) begin
      in_data_b = 32'(v);
      if (v <= 4) qb.push_back(32'(v));
      step();
      if (v == 4) check("t4_done_at4", 32'(done_b), 1);
    end
    cap_en_b = 1'b0;
    check("t4_count", 32'(count_b), 4);
    check("t4_ovf", 32'(ovf_b), 0);
    out_ready_b = 1'b1; step(4); out_ready_b = 1'b0;
    check("t4_empty", 32'(empty_b), 1);
    check("t4_done_held", 32'(done_b), 1);
    cap_en_b = 1'b1; in_data_b = 77; step(); cap_en_b = 1'b0;
    check("t4_no_push", 32'(count_b), 0);
    clr = 1'b1; step(); clr = 1'b0;
    check("t4_done_clr", 32'(done_b), 0);

    // flush by clr, then by reset, mid-capture
    cap_en_a = 1'b1;
    for (int v = 1; v <= 3; v++) begin
      in_data_a = 32'(v); step();
    end
    check("t5_count3", 32'(count_a), 3);
    clr = 1'b1; in_data_a = 9; step(); clr = 1'b0; cap_en_a = 1'b0;
    check("t5_clr_count", 32'(count_a), 0);
    check("t5_clr_empty", 32'(empty_a), 1);
    check("t5_clr_valid", 32'(out_valid_a), 0);
    cap_en_a = 1'b1;
    in_data_a = 4; step(); in_data_a = 5; step();
    rst = 1'b1; in_data_a = 6; step(); rst = 1'b0; cap_en_a = 1'b0;
    check("t5_rst_count", 32'(count_a), 0);
    check("t5_rst_valid", 32'(out_valid_a), 0);

    // repeated values, then a long stream that wraps the pointers
    cap_en_a = 1'b1;
    in_data_a = 5; step(); step(); step();
    in_data_a = 7; step();
    cap_en_a = 1'b0;
`ifdef TRACE_DEDUP_EN
    qa.push_back(5); qa.push_back(7);
    check("t6_count", 32'(count_a), 2);
`else
    qa.push_back(5); qa.push_back(5); qa.push_back(5); qa.push_back(7);
    check("t6_count", 32'(count_a), 4);
`endif
    out_ready_a = 1'b1; step(4);
    cap_en_a = 1'b1;
    for (int i = 0; i < 20; i++) begin
      in_data_a = 32'(100 + i); qa.push_back(32'(100 + i)); step();
    end
    cap_en_a = 1'b0; step(2); out_ready_a = 1'b0;
    check("t6_ovf", 32'(ovf_a), 0);
    check("t6_empty", 32'(empty_a), 1);
    check("sb_a_left", 32'(qa.size()), 0);
    check("sb_b_left", 32'(qb.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
